wdt_host_ctrl: RTL and testbench
================================

// Module: wdt_host_ctrl
// PURPOSE
//  System-clock (clk) register front end that drives the watchdog timer's control inputs: WDEN, WDLIVE, WTOCNT, WTOCNT_load.
//  Stretches the kick (WDLIVE) and load strobes so the slower WDT clock domain samples them.
//  Holds WTOCNT stable across each load handshake.
//  Synchronises WTO back into clk and raises a sticky interrupt on its rising edge.
// PARAMETERS
//  LIVE_HOLD    4  clk cycles WDLIVE is held high per kick (>= 3 WDT clk periods)
//  LOAD_HOLD    4  clk cycles WTOCNT_load is held high per load
//  SETTLE       4  clk cycles WTOCNT stays frozen after load drops
//  SYNC_STAGES  2  flops in the WTO synchroniser (>= 2)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  req_valid    in   1   bus request valid
//  req_ready    out  1   bus request accepted (valid & ready = transfer)
//  req_write    in   1   1 = write, 0 = read
//  req_addr     in   2   word index: 0 CTRL, 1 KICK, 2 TOCNT, 3 STATUS
//  req_wdata    in   32  write data
//  rsp_valid    out  1   read data valid, one cycle after the accepted read
//  rsp_rdata    out  32  read data
//  WTO          in   1   timeout from WDT domain (asynchronous to clk)
//  WDEN         out  1   watchdog enable, = CTRL[0]
//  WDLIVE       out  1   stretched kick strobe
//  WTOCNT       out  32  timeout count, frozen while load_busy
//  WTOCNT_load  out  1   stretched load strobe
//  irq          out  1   = irq_pend & CTRL[1]
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, TOCNT=0, irq_pend=0, sync chain=0, FSM=IDLE.
//  req_ready=1, except: 0 for a TOCNT write while load_busy (the bus stalls; no drop, no queue).
//  Writes take effect on the accepting edge; outputs update the next cycle.
//  Reads: rsp_valid pulses 1 cycle after acceptance, with rdata captured at acceptance; otherwise rsp_rdata=0.
//  Register map:
//    CTRL   RW  [0]=en, [1]=irq_en; other bits read 0.
//    KICK   WO  any write kicks; reads 0.
//    TOCNT  RW  32-bit value; a write starts a load; reads the last written value.
//    STATUS     [0]=wto_s (RO), [1]=load_busy (RO), [2]=live_busy (RO), [3]=irq_pend (W1C).
//  Kick: WDLIVE=1 for LIVE_HOLD cycles.
//    A kick while WDLIVE is high reloads the hold counter (no gap, no extra edge).
//  Load FSM, states IDLE -> LOAD -> SETTLE -> IDLE:
//    IDLE: a TOCNT write latches WTOCNT <= wdata and enters LOAD.
//    LOAD: WTOCNT_load=1 for LOAD_HOLD cycles, then SETTLE.
//    SETTLE: WTOCNT_load=0 for SETTLE cycles, then IDLE.
//    load_busy = (state != IDLE). WTOCNT changes only on the IDLE->LOAD edge.
//  WTO: passes through the SYNC_STAGES chain to wto_s. The rising edge of wto_s sets irq_pend.
//    Set wins over a same-cycle W1C clear.
//  A CTRL write of en=0 does not abort a load or kick in progress.
//  Reset mid-operation aborts everything; WDLIVE and WTOCNT_load drop asynchronously.
//  Counter widths are $clog2(max hold)+1; no wrap is possible.
// STRUCTURE
//  Package wdt_host_pkg:
//    addr enum {A_CTRL, A_KICK, A_TOCNT, A_STATUS}
//    load FSM enum {IDLE, LOAD, SETTLE}
//    STATUS/CTRL bit-index localparams
//  Sub-module pulse_stretch #(HOLD): retriggerable hold counter, used for WDLIVE.
//  Everything else stays in wdt_host_ctrl.
// TESTING
//  1. Reset, then read all 4 regs -> all 0; all outputs 0.
//  2. Write CTRL=0x1 -> WDEN=1 the next cycle; read CTRL -> 0x1.
//  3. Write KICK at t0 and again at t0+2 -> WDLIVE high t0+1..t0+2+LIVE_HOLD (6 cycles), one pulse.
//  4. Write TOCNT=0x100, then TOCNT=0x200 immediately:
//     WTOCNT=0x100 and load high for 4 cycles, then 4 settle cycles.
//     Second write stalled 8 cycles, then WTOCNT=0x200 with a second load pulse.
//  5. CTRL=0x3, raise WTO -> irq=1 after SYNC_STAGES+1 cycles.
//     W1C STATUS=0x8 -> irq=0. Redo with W1C in the same cycle as the set -> irq stays 1.
//  6. Assert rst during LOAD -> WTOCNT_load=0, state IDLE, TOCNT=0; the next TOCNT write completes normally.

Source files
------------

// File: rtl/wdt_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wdt_host_pkg
// Description : Shared types and bit indices for the watchdog host front end.
//               - addr_e       : register word index on the request bus
//               - load_state_e : WTOCNT load handshake FSM states
//               - c_ctrl_* / c_st_* : CTRL and STATUS bit positions
// Revision    : 1.0  initial release
// ============================================================================
package wdt_host_pkg;

  typedef enum logic [1:0] {
    A_CTRL   = 2'd0,
    A_KICK   = 2'd1,
    A_TOCNT  = 2'd2,
    A_STATUS = 2'd3
  } addr_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2
  } load_state_e;

  // CTRL bit positions
  localparam int c_ctrl_en     = 0;
  localparam int c_ctrl_irq_en = 1;

  // STATUS bit positions
  localparam int c_st_wto       = 0;
  localparam int c_st_load_busy = 1;
  localparam int c_st_live_busy = 2;
  localparam int c_st_irq_pend  = 3;

endpackage : wdt_host_pkg
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_stretch
// Description : Retriggerable strobe stretcher. A one-cycle trig makes pulse
//               high for HOLD cycles starting the next cycle; a trig while
//               pulse is high restarts the hold with no gap.
// Ports       : clk   in  system clock
//               rst   in  asynchronous active-low reset
//               trig  in  one-cycle trigger
//               pulse out stretched, registered strobe
// Revision    : 1.0  initial release
// ============================================================================
module pulse_stretch #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(HOLD) + 1;

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // r_cnt counts the remaining cycles after the current one; the output is a
  // flop so the slow domain never sees a decode glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (trig) begin
      r_cnt   <= CW'(HOLD - 1);
      r_pulse <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - CW'(1);
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign pulse = r_pulse;

endmodule : pulse_stretch
`default_nettype wire

// File: rtl/wdt_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wdt_host_ctrl
// Description : clk-domain register front end for the watchdog timer.
//               Drives WDEN/WDLIVE/WTOCNT/WTOCNT_load, stretches the kick and
//               load strobes for the slower WDT clock, freezes WTOCNT over
//               each load handshake, synchronises WTO and raises a sticky irq.
// Ports       : clk, rst (async active-low)
//               req_valid/req_ready/req_write/req_addr/req_wdata : bus request
//               rsp_valid/rsp_rdata : read response, one cycle after accept
//               WTO : timeout from the WDT domain (async)
//               WDEN, WDLIVE, WTOCNT, WTOCNT_load : WDT control inputs
//               irq : irq_pend & CTRL.irq_en
// Revision    : 1.0  initial release
// ============================================================================
module wdt_host_ctrl #(
  parameter int LIVE_HOLD   = 4,
  parameter int LOAD_HOLD   = 4,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        WTO,
  output logic        WDEN,
  output logic        WDLIVE,
  output logic [31:0] WTOCNT,
  output logic        WTOCNT_load,
  output logic        irq
);

  import wdt_host_pkg::*;

  localparam int C_MAX_HOLD = (LOAD_HOLD > SETTLE) ? LOAD_HOLD : SETTLE;
  localparam int CW         = $clog2(C_MAX_HOLD) + 1;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  load_state_e r_state, w_state_nxt;
  logic        w_load_busy;
  logic        w_wr, w_rd;
  logic        w_kick, w_load_start, w_w1c;

  assign w_load_busy = (r_state != IDLE);

  // A TOCNT write during a handshake is held off rather than dropped.
  assign req_ready = ~(req_write && (req_addr == A_TOCNT) && w_load_busy);

  assign w_wr         = req_valid & req_ready & req_write;
  assign w_rd         = req_valid & req_ready & ~req_write;
  assign w_kick       = w_wr & (req_addr == A_KICK);
  assign w_load_start = w_wr & (req_addr == A_TOCNT);
  assign w_w1c        = w_wr & (req_addr == A_STATUS) & req_wdata[c_st_irq_pend];

  // --------------------------------------------------------------------------
  // CTRL register
  // --------------------------------------------------------------------------
  logic r_ctrl_en, r_ctrl_irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl_en     <= 1'b0;
      r_ctrl_irq_en <= 1'b0;
    end else if (w_wr && (req_addr == A_CTRL)) begin
      r_ctrl_en     <= req_wdata[c_ctrl_en];
      r_ctrl_irq_en <= req_wdata[c_ctrl_irq_en];
    end
  end

  assign WDEN = r_ctrl_en;

  // --------------------------------------------------------------------------
  // Kick stretcher
  // --------------------------------------------------------------------------
  logic w_live;

  pulse_stretch #(
    .HOLD (LIVE_HOLD)
  ) u_live (
    .clk   (clk),
    .rst   (rst),
    .trig  (w_kick),
    .pulse (w_live)
  );

  assign WDLIVE = w_live;

  // --------------------------------------------------------------------------
  // Load handshake FSM
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_tocnt;
  logic          r_load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_load_start) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = CW'(LOAD_HOLD - 1);
        end
      end
      LOAD: begin
        if (r_cnt == '0) begin
          w_state_nxt = wdt_host_pkg::SETTLE;
          w_cnt_nxt   = CW'(SETTLE - 1);
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      wdt_host_pkg::SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The TOCNT register doubles as the WTOCNT driver: it can only change on
  // the IDLE->LOAD edge because writes are stalled while busy. The strobe is
  // a flop fed from the next state so it is glitch free for the WDT domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tocnt <= '0;
      r_load  <= 1'b0;
    end else begin
      r_load <= (w_state_nxt == LOAD);
      if (w_load_start) begin
        r_tocnt <= req_wdata;
      end
    end
  end

  assign WTOCNT      = r_tocnt;
  assign WTOCNT_load = r_load;

  // --------------------------------------------------------------------------
  // WTO synchroniser, edge detect and sticky interrupt
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_wto_s;
  logic                   r_wto_d;
  logic                   r_irq_pend;
  logic                   w_wto_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], WTO};
    end
  end

  assign w_wto_s    = r_sync[SYNC_STAGES-1];
  assign w_wto_rise = w_wto_s & ~r_wto_d;

  // A new timeout edge beats a same-cycle W1C so no event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wto_d    <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      r_wto_d <= w_wto_s;
      if (w_wto_rise) begin
        r_irq_pend <= 1'b1;
      end else if (w_w1c) begin
        r_irq_pend <= 1'b0;
      end
    end
  end

  assign irq = r_irq_pend & r_ctrl_irq_en;

  // --------------------------------------------------------------------------
  // Read path: data captured at acceptance, presented for one cycle
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;

  always_comb begin
    w_rdata = '0;
    case (req_addr)
      A_CTRL: begin
        w_rdata[c_ctrl_en]     = r_ctrl_en;
        w_rdata[c_ctrl_irq_en] = r_ctrl_irq_en;
      end
      A_TOCNT: begin
        w_rdata = r_tocnt;
      end
      A_STATUS: begin
        w_rdata[c_st_wto]       = w_wto_s;
        w_rdata[c_st_load_busy] = w_load_busy;
        w_rdata[c_st_live_busy] = w_live;
        w_rdata[c_st_irq_pend]  = r_irq_pend;
      end
      default: begin
        w_rdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      r_rsp_rdata <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule : wdt_host_ctrl
`default_nettype wire

// File: tb/tb_wdt_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wdt_host_ctrl
// Description : Self-checking bench for wdt_host_ctrl. Register accesses come
//               from a vector table; read data and load values are checked
//               against scoreboard queues filled when stimulus is issued.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wdt_host_ctrl;

  localparam int LIVE_HOLD   = 4;
  localparam int LOAD_HOLD   = 4;
  localparam int SETTLE      = 4;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        WTO = 1'b0;
  logic        WDEN, WDLIVE, WTOCNT_load, irq;
  logic [31:0] WTOCNT;

  wdt_host_ctrl #(
    .LIVE_HOLD   (LIVE_HOLD),
    .LOAD_HOLD   (LOAD_HOLD),
    .SETTLE      (SETTLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .WTO         (WTO),
    .WDEN        (WDEN),
    .WDLIVE      (WDLIVE),
    .WTOCNT      (WTOCNT),
    .WTOCNT_load (WTOCNT_load),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scoreboards ----------------
  logic [31:0] rd_q[$];
  logic [31:0] load_q[$];

  // Read responses: pop expected data on each rsp_valid; idle rdata must be 0.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rsp_valid === 1'b1) begin
        if (rd_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_rdata", rsp_rdata, rd_q.pop_front());
      end else begin
        check("rsp_idle_zero", rsp_rdata, 32'd0);
      end
    end
  end

  // Load strobe: each pulse must carry the next written value and last LOAD_HOLD cycles.
  int          load_run = 0;
  int          load_pulses = 0;
  logic [31:0] load_exp = '0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      load_run = 0;
    end else if (WTOCNT_load === 1'b1) begin
      if (load_run == 0) begin
        load_pulses++;
        if (load_q.size() == 0) begin
          check("load_unexpected", 32'd1, 32'd0);
          load_exp = WTOCNT;
        end else begin
          load_exp = load_q.pop_front();
          check("wtocnt_at_load", WTOCNT, load_exp);
        end
      end
      load_run++;
    end else if (load_run != 0) begin
      check("load_len", load_run, LOAD_HOLD);
      check("wtocnt_frozen", WTOCNT, load_exp);
      load_run = 0;
    end
  end

  // Kick strobe: count high cycles and rising edges.
  int   live_cycles = 0;
  int   live_rises  = 0;
  logic live_prev   = 1'b0;
  always @(negedge clk) begin
    if (WDLIVE === 1'b1) begin
      live_cycles++;
      if (!live_prev) live_rises++;
    end
    live_prev = (WDLIVE === 1'b1);
  end

  // ---------------- bus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    stalls = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 50) check("write_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    rd_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_wden;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    vecs[0] = '{0, 2'd0, 32'h0,        32'h0, 1'b0};
    vecs[1] = '{0, 2'd1, 32'h0,        32'h0, 1'b0};
    vecs[2] = '{0, 2'd2, 32'h0,        32'h0, 1'b0};
    vecs[3] = '{0, 2'd3, 32'h0,        32'h0, 1'b0};
    vecs[4] = '{1, 2'd0, 32'h1,        32'h0, 1'b1};
    vecs[5] = '{0, 2'd0, 32'h0,        32'h1, 1'b1};
    vecs[6] = '{1, 2'd0, 32'hFFFF_FFFE, 32'h0, 1'b0};
    vecs[7] = '{0, 2'd0, 32'h0,        32'h2, 1'b0};
    vecs[8] = '{1, 2'd0, 32'h1,        32'h0, 1'b1};
    vecs[9] = '{0, 2'd0, 32'h0,        32'h1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_WDEN", WDEN, 0);
    check("rst_WDLIVE", WDLIVE, 0);
    check("rst_WTOCNT", WTOCNT, 0);
    check("rst_load", WTOCNT_load, 0);
    check("rst_irq", irq, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    tick();
    rst = 1'b1;
    tick();

    // Register map / CTRL behaviour from the table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data, st);
        check("vec_stall", st, 0);
      end else begin
        bus_read(vecs[i].addr, vecs[i].exp_rd);
      end
      @(negedge clk);
      check("vec_WDEN", WDEN, vecs[i].exp_wden);
      tick();
    end

    // Kick at t0 and t0+2: one pulse, 6 cycles long
    repeat (6) tick();
    live_cycles = 0; live_rises = 0;
    bus_write(2'd1, 32'h0, st);
    @(negedge clk);
    check("live_first_cycle", WDLIVE, 1);
    tick();
    bus_write(2'd1, 32'hDEAD, st);
    repeat (10) tick();
    check("live_cycles", live_cycles, 2 + LIVE_HOLD);
    check("live_rises", live_rises, 1);

    // Back-to-back TOCNT writes: second stalls for LOAD_HOLD+SETTLE cycles
    load_pulses = 0;
    load_q.push_back(32'h100);
    bus_write(2'd2, 32'h100, st);
    check("tocnt1_stall", st, 0);
    load_q.push_back(32'h200);
    bus_write(2'd2, 32'h200, st);
    check("tocnt2_stall", st, LOAD_HOLD + SETTLE);
    @(negedge clk);
    check("wtocnt_second", WTOCNT, 32'h200);
    repeat (LOAD_HOLD + SETTLE + 2) tick();
    check("load_pulses", load_pulses, 2);
    bus_read(2'd2, 32'h200);
    tick();

    // WTO -> irq latency, W1C clear, and set-beats-clear
    bus_write(2'd0, 32'h3, st);
    WTO = 1'b1;
    for (int k = 0; k <= SYNC_STAGES + 1; k++) begin
      @(negedge clk);
      check("irq_latency", irq, (k == SYNC_STAGES + 1) ? 1 : 0);
      tick();
    end
    bus_read(2'd3, 32'h9);
    bus_write(2'd3, 32'h8, st);
    @(negedge clk);
    check("irq_w1c", irq, 0);
    tick();
    bus_read(2'd3, 32'h1);
    WTO = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
    WTO = 1'b1;
    tick();
    tick();
    bus_write(2'd3, 32'h8, st);
    @(negedge clk);
    check("irq_set_wins", irq, 1);
    tick();
    bus_read(2'd3, 32'h9);
    WTO = 1'b0;
    repeat (SYNC_STAGES + 3) tick();

    // Reset during LOAD
    load_q.push_back(32'h55);
    bus_write(2'd2, 32'h55, st);
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_load", WTOCNT_load, 0);
    check("rst_async_wtocnt", WTOCNT, 0);
    check("rst_async_irq", irq, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    bus_read(2'd3, 32'h0);
    bus_read(2'd2, 32'h0);
    load_pulses = 0;
    load_q.push_back(32'h77);
    bus_write(2'd2, 32'h77, st);
    check("post_rst_stall", st, 0);
    repeat (LOAD_HOLD + SETTLE + 2) tick();
    check("post_rst_pulses", load_pulses, 1);
    bus_read(2'd2, 32'h77);
    repeat (3) tick();

    check("rd_q_drained", rd_q.size(), 0);
    check("load_q_drained", load_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wdt_host_ctrl
`default_nettype wire
